// File: rtl/uart_rx_param.sv
// Parametrised serial receiver: synchronised input, false-start rejection,
// optional odd/even parity and 1 or 2 stop bits, one-cycle valid strobe per word.
module uart_rx_param #(
    parameter int unsigned DIV       = 10417,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] dout_o,
    output logic                 valid_o,
    output logic                 perr_o,
    output logic                 ferr_o,
    output logic                 busy_o
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] HalfM1   = CntW'(DIV / 2 - 1);
    localparam logic [CntW-1:0] DivM1    = CntW'(DIV - 1);
    localparam logic [3:0]      LastData = 4'(DATA_BITS - 1);
    localparam logic [3:0]      LastStop = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StPar,
        StStop,
        StDone
    } state_e;

    state_e                 state_q;
    logic [CntW-1:0]        cnt_q;
    logic [3:0]             idx_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   par_q;
    logic                   perr_q;
    logic                   ferr_q;
    logic                   sync1_q;
    logic                   sync2_q;
    logic                   hist_q;
    logic                   fall;

    // Two-flop synchroniser plus one history flop; all idle high.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign fall   = hist_q & ~sync2_q;
    assign busy_o = (state_q != StIdle);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            dout_o  <= '0;
            valid_o <= 1'b0;
            perr_o  <= 1'b0;
            ferr_o  <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (fall) begin
                        state_q <= StStart;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end
                end
                StStart: begin
                    if (cnt_q == HalfM1) begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        par_q   <= 1'b0;
                        perr_q  <= 1'b0;
                        ferr_q  <= 1'b0;
                        // A line already back high at mid-start is a glitch.
                        state_q <= sync2_q ? StIdle : StData;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (cnt_q == DivM1) begin
                        cnt_q <= '0;
                        if (DATA_BITS > 1) begin
                            shift_q <= {sync2_q, shift_q[DATA_BITS-1:1]};
                        end else begin
                            shift_q <= sync2_q;
                        end
                        par_q <= par_q ^ sync2_q;
                        if (idx_q == LastData) begin
                            idx_q   <= '0;
                            state_q <= (PARITY != 0) ? StPar : StStop;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StPar: begin
                    if (cnt_q == DivM1) begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        perr_q  <= (PARITY == 1) ? ~(par_q ^ sync2_q) : (par_q ^ sync2_q);
                        state_q <= StStop;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StStop: begin
                    if (cnt_q == DivM1) begin
                        cnt_q <= '0;
                        if (!sync2_q) begin
                            ferr_q <= 1'b1;
                        end
                        if (idx_q == LastStop) begin
                            idx_q   <= '0;
                            state_q <= StDone;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    dout_o  <= shift_q;
                    perr_o  <= perr_q;
                    ferr_o  <= ferr_q;
                    valid_o <= 1'b1;
                    cnt_q   <= '0;
                    idx_q   <= '0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
